// File: rtl/cache_ctrl_pkg.sv
// Shared encodings for the data-cache sequencing FSM: state codes (as seen on
// state_dbg), CPU opcodes and cache-array commands.
package cache_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CLEAR   = 4'd1,
    ST_LOOKUP  = 4'd2,
    ST_CHECK   = 4'd3,
    ST_EVICT   = 4'd4,
    ST_FILL    = 4'd5,
    ST_INSTALL = 4'd6,
    ST_ACCESS  = 4'd7,
    ST_PTR     = 4'd8,
    ST_ERR     = 4'd9,
    ST_DONE    = 4'd10
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_NOP   = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;

  localparam logic [1:0] CI_CLEAR = 2'b00;
  localparam logic [1:0] CI_LOAD  = 2'b01;
  localparam logic [1:0] CI_HOLD  = 2'b10;
  localparam logic [1:0] CI_WRITE = 2'b11;

  function automatic logic is_ram_wait(input state_t s);
    return (s == ST_EVICT) || (s == ST_FILL);
  endfunction

endpackage

// File: rtl/cache_ctrl_timer.sv
// Loadable saturating down-counter; expired is high while the count is zero.
module cache_ctrl_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/cache_ctrl_seq.sv
// Direct-mapped data-cache sequencer: clear/read/write with pointer indirection.
// Define CACHE_CTRL_TIMEOUT_EN to bound EVICT/FILL waits by RAM_TIMEOUT cycles.
module cache_ctrl_seq
  import cache_ctrl_pkg::*;
#(
  parameter int MAX_IND     = 2,
  parameter int CLR_CYCLES  = 1,
  parameter int RAM_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req,
  input  logic [1:0]                     ctrl,
  input  logic [$clog2(MAX_IND+1)-1:0]   ind_level,
  input  logic                           is_hit,
  input  logic                           is_clean,
  input  logic                           ram_ready,
  output logic [1:0]                     cache_in,
  output logic                           data_in_sel,
  output logic                           ram_rd_en,
  output logic                           ram_wr_en,
  output logic                           ptr_load,
  output logic                           out_ready,
  output logic                           done,
  output logic                           busy,
  output logic                           err,
  output logic [3:0]                     state_dbg
);

  localparam int LW = $clog2(MAX_IND + 1);
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [LW:0]   MAX_LVL  = (LW + 1)'(MAX_IND);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [1:0]    op_reg, op_next;
  logic [LW-1:0] level_reg, level_next;
  logic          err_reg, err_next;
  logic [CW-1:0] clr_cnt_reg;
  logic          accept;
  logic          final_write;

  logic [1:0] cache_in_reg, cache_in_next;
  logic       data_in_sel_reg, data_in_sel_next;
  logic       ram_rd_en_reg, ram_wr_en_reg, ptr_load_reg;
  logic       out_ready_reg, out_ready_next;
  logic       done_reg, busy_reg;

`ifdef CACHE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(RAM_TIMEOUT + 1);
  logic timer_expired;

  // Reloads on every state change, so EVICT->FILL gets a fresh budget.
  cache_ctrl_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_next != state_reg),
    .load_val (TW'(RAM_TIMEOUT - 1)),
    .en       (is_ram_wait(state_reg)),
    .expired  (timer_expired)
  );
`endif

  // A write at its final level is no-allocate: it never fills the line.
  assign final_write = (op_reg == OP_WRITE) && (level_reg == '0);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          accept = 1'b1;
          case (ctrl)
            OP_CLEAR: state_next = ST_CLEAR;
            OP_NOP:   state_next = ST_DONE;
            default:  state_next = ({1'b0, ind_level} > MAX_LVL) ? ST_ERR : ST_LOOKUP;
          endcase
        end
      end
      ST_CLEAR:   if (clr_cnt_reg == '0) state_next = ST_DONE;
      ST_LOOKUP:  state_next = ST_CHECK;
      ST_CHECK: begin
        if (is_hit)        state_next = ST_ACCESS;
        else if (is_clean) state_next = final_write ? ST_ACCESS : ST_FILL;
        else               state_next = ST_EVICT;
      end
      ST_EVICT: begin
        if (ram_ready) state_next = final_write ? ST_ACCESS : ST_FILL;
`ifdef CACHE_CTRL_TIMEOUT_EN
        else if (timer_expired) state_next = ST_ERR;
`endif
      end
      ST_FILL: begin
        if (ram_ready) state_next = ST_INSTALL;
`ifdef CACHE_CTRL_TIMEOUT_EN
        else if (timer_expired) state_next = ST_ERR;
`endif
      end
      ST_INSTALL: state_next = ST_ACCESS;
      ST_ACCESS:  state_next = (level_reg != '0) ? ST_PTR : ST_DONE;
      ST_PTR:     state_next = ST_LOOKUP;
      ST_ERR:     state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    op_next    = accept ? ctrl : op_reg;
    level_next = accept ? ind_level
               : ((state_reg == ST_PTR) ? level_reg - 1'b1 : level_reg);
    if (state_next == ST_ERR) err_next = 1'b1;
    else if (accept)          err_next = 1'b0;
    else                      err_next = err_reg;
  end

  // Outputs are decoded from the next state and registered with it.
  always_comb begin
    cache_in_next    = CI_HOLD;
    data_in_sel_next = 1'b0;
    out_ready_next   = 1'b0;
    case (state_next)
      ST_CLEAR:   cache_in_next = CI_CLEAR;
      ST_LOOKUP:  cache_in_next = CI_LOAD;
      ST_INSTALL: begin
        cache_in_next    = CI_WRITE;
        data_in_sel_next = 1'b1;
      end
      ST_ACCESS:  if (op_next == OP_WRITE && level_next == '0) cache_in_next = CI_WRITE;
      ST_DONE:    out_ready_next = op_next[1] && !err_next;
      default:    cache_in_next = CI_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      op_reg          <= OP_NOP;
      level_reg       <= '0;
      err_reg         <= 1'b0;
      clr_cnt_reg     <= '0;
      cache_in_reg    <= CI_HOLD;
      data_in_sel_reg <= 1'b0;
      ram_rd_en_reg   <= 1'b0;
      ram_wr_en_reg   <= 1'b0;
      ptr_load_reg    <= 1'b0;
      out_ready_reg   <= 1'b0;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      level_reg <= level_next;
      err_reg   <= err_next;
      if (state_next == ST_CLEAR && state_reg != ST_CLEAR) clr_cnt_reg <= CLR_LAST;
      else if (state_reg == ST_CLEAR && clr_cnt_reg != '0) clr_cnt_reg <= clr_cnt_reg - 1'b1;
      cache_in_reg    <= cache_in_next;
      data_in_sel_reg <= data_in_sel_next;
      ram_rd_en_reg   <= (state_next == ST_FILL);
      ram_wr_en_reg   <= (state_next == ST_EVICT);
      ptr_load_reg    <= (state_next == ST_PTR);
      out_ready_reg   <= out_ready_next;
      done_reg        <= (state_next == ST_DONE);
      busy_reg        <= (state_next != ST_IDLE);
    end
  end

  assign cache_in    = cache_in_reg;
  assign data_in_sel = data_in_sel_reg;
  assign ram_rd_en   = ram_rd_en_reg;
  assign ram_wr_en   = ram_wr_en_reg;
  assign ptr_load    = ptr_load_reg;
  assign out_ready   = out_ready_reg;
  assign done        = done_reg;
  assign busy        = busy_reg;
  assign err         = err_reg;
  assign state_dbg   = state_reg;

endmodule

// File: tb/tb_cache_ctrl_seq.sv
// Self-checking bench for cache_ctrl_seq: directed scenarios plus randomized
// requests scored against a cycle-count reference model.
module tb_cache_ctrl_seq;

  localparam int MAX_IND = 2;
  localparam int CLR     = 4;
  localparam int TMO     = 8;
  localparam int LW      = $clog2(MAX_IND + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    ctrl = 2'b01;
  logic [LW-1:0] ind_level = '0;
  logic          is_hit = 1'b0;
  logic          is_clean = 1'b0;
  logic          ram_ready = 1'b0;
  logic [1:0]    cache_in;
  logic          data_in_sel, ram_rd_en, ram_wr_en, ptr_load;
  logic          out_ready, done, busy, err;
  logic [3:0]    state_dbg;

  always #5 clk = ~clk;

  cache_ctrl_seq #(.MAX_IND(MAX_IND), .CLR_CYCLES(CLR), .RAM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ctrl(ctrl), .ind_level(ind_level),
    .is_hit(is_hit), .is_clean(is_clean), .ram_ready(ram_ready),
    .cache_in(cache_in), .data_in_sel(data_in_sel), .ram_rd_en(ram_rd_en),
    .ram_wr_en(ram_wr_en), .ptr_load(ptr_load), .out_ready(out_ready),
    .done(done), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  bit hit_a[4];
  bit clean_a[4];

  // Observations from the latest request
  int         o_done, o_wr, o_rd, o_ptr, o_inst, o_fw, o_clr, o_nb;
  logic       o_ordy, o_err, o_idle_busy, o_idle_err;
  logic [3:0] o_idle_state;

  // Reference model expectations
  int e_done, e_wr, e_rd, e_ptr, e_inst, e_fw, e_clr;
  bit e_ordy, e_err;

  // Cycle-count model: each hop costs lookup+check, any RAM traffic it needs,
  // and the access; every non-final hop adds one pointer-load cycle.
  task automatic model_req(input logic [1:0] c, input int lv, input int wl, input int rl);
    int  t;
    bit  fin;
    e_wr = 0; e_rd = 0; e_ptr = 0; e_inst = 0; e_fw = 0; e_clr = 0;
    e_ordy = 1'b0; e_err = 1'b0;
    if (c == 2'b00) begin
      e_clr = CLR; e_done = CLR + 1;
    end else if (c == 2'b01) begin
      e_done = 1;
    end else if (lv > MAX_IND) begin
      e_err = 1'b1; e_done = 2;
    end else begin
      t = 0;
      for (int h = 0; h <= lv; h++) begin
        fin = (h == lv);
        t += 2;
        if (!hit_a[h]) begin
          if (!clean_a[h]) begin t += wl; e_wr += wl; end
          if (!(c == 2'b11 && fin)) begin
            t += rl + 1; e_rd += rl; e_inst++;
          end
        end
        t += 1;
        if (!fin) begin t += 1; e_ptr++; end
      end
      e_fw   = (c == 2'b11) ? 1 : 0;
      e_ordy = 1'b1;
      e_done = t + 1;
    end
  endtask

  // Issues one request from IDLE (called at a negedge) and tallies outputs per
  // cycle until done; wl/rl are RAM latencies in strobe cycles (0 = never ready).
  task automatic run_req(input logic [1:0] c, input int lv, input int wl, input int rl,
                         input bit hold);
    int cyc, wcnt, rcnt;
    o_done = -1; o_wr = 0; o_rd = 0; o_ptr = 0; o_inst = 0; o_fw = 0; o_clr = 0; o_nb = 0;
    o_ordy = 1'b0; o_err = 1'b0;
    is_hit = hit_a[0]; is_clean = clean_a[0];
    ctrl = c; ind_level = LW'(lv); req = 1'b1;
    cyc = 0; wcnt = 0; rcnt = 0;
    while (o_done < 0 && cyc < 300) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (hold) begin
        req = 1'($urandom); ctrl = 2'($urandom); ind_level = LW'($urandom);
      end else begin
        req = 1'b0;
      end
      if (ram_wr_en) begin o_wr++; wcnt++; end else wcnt = 0;
      if (ram_rd_en) begin o_rd++; rcnt++; end else rcnt = 0;
      if (ram_wr_en)      ram_ready = (wl > 0) && (wcnt >= wl);
      else if (ram_rd_en) ram_ready = (rl > 0) && (rcnt >= rl);
      else                ram_ready = 1'($urandom);
      if (ptr_load) o_ptr++;
      is_hit = hit_a[o_ptr & 3]; is_clean = clean_a[o_ptr & 3];
      if (cache_in == 2'b11 && data_in_sel)  o_inst++;
      if (cache_in == 2'b11 && !data_in_sel) o_fw++;
      if (cache_in == 2'b00) o_clr++;
      if (!busy) o_nb++;
      if (done) begin
        o_done = cyc; o_ordy = out_ready; o_err = err; req = 1'b0;
      end
    end
    ram_ready = 1'b0; req = 1'b0;
    @(posedge clk); @(negedge clk);
    o_idle_busy = busy; o_idle_err = err; o_idle_state = state_dbg;
    $display("txn ctrl=%b lvl=%0d done@%0d wr=%0d rd=%0d ptr=%0d inst=%0d ordy=%b err=%b",
             c, lv, o_done, o_wr, o_rd, o_ptr, o_inst, o_ordy, o_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cache_in !== 2'b10) $display("FAIL reset_cache_in: got %b expected 10", cache_in); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (state_dbg !== 4'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg); else n_pass++;
    n_checks++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset_done_err: got %b%b expected 00", done, err); else n_pass++;
    n_checks++; if ((ram_rd_en | ram_wr_en | ptr_load | out_ready | data_in_sel) !== 1'b0)
      $display("FAIL reset_strobes: got %b%b%b%b%b expected 00000", ram_rd_en, ram_wr_en, ptr_load, out_ready, data_in_sel);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_read_hit();
    for (int h = 0; h < 4; h++) begin hit_a[h] = 1'b1; clean_a[h] = 1'b1; end
    run_req(2'b10, 0, 1, 1, 1'b0);
    n_checks++; if (o_done !== 4) $display("FAIL hit_done_cycle: got %0d expected 4", o_done); else n_pass++;
    n_checks++; if (o_wr + o_rd !== 0) $display("FAIL hit_ram_strobes: got %0d expected 0", o_wr + o_rd); else n_pass++;
    n_checks++; if (o_ordy !== 1'b1) $display("FAIL hit_out_ready: got %b expected 1", o_ordy); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL hit_err: got %b expected 0", o_err); else n_pass++;
    n_checks++; if (o_idle_state !== 4'd0) $display("FAIL hit_back_idle: got %0d expected 0", o_idle_state); else n_pass++;
  endtask

  task automatic test_dirty_miss();
    hit_a[0] = 1'b0; clean_a[0] = 1'b0;
    run_req(2'b10, 0, 3, 3, 1'b0);
    n_checks++; if (o_wr !== 3) $display("FAIL dirty_wr_cycles: got %0d expected 3", o_wr); else n_pass++;
    n_checks++; if (o_rd !== 3) $display("FAIL dirty_rd_cycles: got %0d expected 3", o_rd); else n_pass++;
    n_checks++; if (o_inst !== 1) $display("FAIL dirty_install: got %0d expected 1", o_inst); else n_pass++;
    n_checks++; if (o_done !== 11) $display("FAIL dirty_done_cycle: got %0d expected 11", o_done); else n_pass++;
    n_checks++; if (o_ordy !== 1'b1) $display("FAIL dirty_out_ready: got %b expected 1", o_ordy); else n_pass++;
  endtask

  task automatic test_indirect_write();
    for (int h = 0; h < 4; h++) begin hit_a[h] = 1'b1; clean_a[h] = 1'b1; end
    run_req(2'b11, 2, 1, 1, 1'b0);
    n_checks++; if (o_ptr !== 2) $display("FAIL ind_ptr_pulses: got %0d expected 2", o_ptr); else n_pass++;
    n_checks++; if (o_fw !== 1) $display("FAIL ind_final_write: got %0d expected 1", o_fw); else n_pass++;
    n_checks++; if (o_inst !== 0) $display("FAIL ind_install: got %0d expected 0", o_inst); else n_pass++;
    n_checks++; if (o_done !== 12) $display("FAIL ind_done_cycle: got %0d expected 12", o_done); else n_pass++;
    n_checks++; if (o_ordy !== 1'b1) $display("FAIL ind_out_ready: got %b expected 1", o_ordy); else n_pass++;
  endtask

  task automatic test_clear_busy_req();
    run_req(2'b00, 0, 1, 1, 1'b1);
    n_checks++; if (o_clr !== CLR) $display("FAIL clr_cycles: got %0d expected %0d", o_clr, CLR); else n_pass++;
    n_checks++; if (o_done !== CLR + 1) $display("FAIL clr_done_cycle: got %0d expected %0d", o_done, CLR + 1); else n_pass++;
    n_checks++; if (o_ordy !== 1'b0) $display("FAIL clr_out_ready: got %b expected 0", o_ordy); else n_pass++;
    n_checks++; if (o_nb !== 0) $display("FAIL clr_busy_gap: got %0d expected 0", o_nb); else n_pass++;
    run_req(2'b01, 0, 1, 1, 1'b0);
    n_checks++; if (o_done !== 1) $display("FAIL nop_done_cycle: got %0d expected 1", o_done); else n_pass++;
  endtask

  task automatic test_bad_level();
    for (int h = 0; h < 4; h++) begin hit_a[h] = 1'b1; clean_a[h] = 1'b1; end
    run_req(2'b10, 3, 1, 1, 1'b0);
    n_checks++; if (o_done !== 2) $display("FAIL bad_done_cycle: got %0d expected 2", o_done); else n_pass++;
    n_checks++; if (o_err !== 1'b1) $display("FAIL bad_err: got %b expected 1", o_err); else n_pass++;
    n_checks++; if (o_ordy !== 1'b0) $display("FAIL bad_out_ready: got %b expected 0", o_ordy); else n_pass++;
    n_checks++; if (o_idle_err !== 1'b1) $display("FAIL bad_err_sticky: got %b expected 1", o_idle_err); else n_pass++;
    run_req(2'b10, 0, 1, 1, 1'b0);
    n_checks++; if (o_err !== 1'b0) $display("FAIL bad_err_cleared: got %b expected 0", o_err); else n_pass++;
    n_checks++; if (o_done !== 4) $display("FAIL bad_next_done: got %0d expected 4", o_done); else n_pass++;
  endtask

`ifdef CACHE_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    hit_a[0] = 1'b0; clean_a[0] = 1'b1;
    run_req(2'b10, 0, 1, 0, 1'b0);
    n_checks++; if (o_rd !== TMO) $display("FAIL tmo_rd_cycles: got %0d expected %0d", o_rd, TMO); else n_pass++;
    n_checks++; if (o_done !== TMO + 4) $display("FAIL tmo_done_cycle: got %0d expected %0d", o_done, TMO + 4); else n_pass++;
    n_checks++; if (o_err !== 1'b1) $display("FAIL tmo_err: got %b expected 1", o_err); else n_pass++;
    n_checks++; if (o_ordy !== 1'b0) $display("FAIL tmo_out_ready: got %b expected 0", o_ordy); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_fill();
    bit seen;
    int cyc;
    hit_a[0] = 1'b0; clean_a[0] = 1'b1;
    is_hit = 1'b0; is_clean = 1'b1; ram_ready = 1'b0;
    ctrl = 2'b10; ind_level = '0; req = 1'b1;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); @(negedge clk);
      cyc++; req = 1'b0;
      if (ram_rd_en) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL mid_fill_reached: got %b expected 1", seen); else n_pass++;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (ram_rd_en !== 1'b0) $display("FAIL mid_rst_rd_en: got %b expected 0", ram_rd_en); else n_pass++;
    n_checks++; if (cache_in !== 2'b10) $display("FAIL mid_rst_cache_in: got %b expected 10", cache_in); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (state_dbg !== 4'd0) $display("FAIL mid_rst_state: got %0d expected 0", state_dbg); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    hit_a[0] = 1'b1;
    run_req(2'b10, 0, 1, 1, 1'b0);
    n_checks++; if (o_done !== 4) $display("FAIL post_rst_done: got %0d expected 4", o_done); else n_pass++;
    n_checks++; if (o_idle_busy !== 1'b0) $display("FAIL post_rst_busy: got %b expected 0", o_idle_busy); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] c;
    int lv, wl, rl;
    bit hold;
    for (int i = 0; i < 40; i++) begin
      c = 2'($urandom);
      lv = $urandom_range(0, 3);
      wl = $urandom_range(1, 4);
      rl = $urandom_range(1, 4);
      hold = 1'($urandom);
      for (int h = 0; h < 4; h++) begin
        hit_a[h] = 1'($urandom); clean_a[h] = 1'($urandom);
      end
      model_req(c, lv, wl, rl);
      run_req(c, lv, wl, rl, hold);
      n_checks++; if (o_done !== e_done) $display("FAIL rnd%0d_done: got %0d expected %0d", i, o_done, e_done); else n_pass++;
      n_checks++; if (o_wr !== e_wr) $display("FAIL rnd%0d_wr: got %0d expected %0d", i, o_wr, e_wr); else n_pass++;
      n_checks++; if (o_rd !== e_rd) $display("FAIL rnd%0d_rd: got %0d expected %0d", i, o_rd, e_rd); else n_pass++;
      n_checks++; if (o_ptr !== e_ptr) $display("FAIL rnd%0d_ptr: got %0d expected %0d", i, o_ptr, e_ptr); else n_pass++;
      n_checks++; if (o_inst !== e_inst) $display("FAIL rnd%0d_install: got %0d expected %0d", i, o_inst, e_inst); else n_pass++;
      n_checks++; if (o_fw !== e_fw) $display("FAIL rnd%0d_final_write: got %0d expected %0d", i, o_fw, e_fw); else n_pass++;
      n_checks++; if (o_clr !== e_clr) $display("FAIL rnd%0d_clear: got %0d expected %0d", i, o_clr, e_clr); else n_pass++;
      n_checks++; if (o_ordy !== e_ordy) $display("FAIL rnd%0d_out_ready: got %b expected %b", i, o_ordy, e_ordy); else n_pass++;
      n_checks++; if (o_err !== e_err) $display("FAIL rnd%0d_err: got %b expected %b", i, o_err, e_err); else n_pass++;
      n_checks++; if (o_nb !== 0) $display("FAIL rnd%0d_busy_gap: got %0d expected 0", i, o_nb); else n_pass++;
      n_checks++; if (o_idle_busy !== 1'b0) $display("FAIL rnd%0d_idle_busy: got %b expected 0", i, o_idle_busy); else n_pass++;
      n_checks++; if (o_idle_err !== e_err) $display("FAIL rnd%0d_idle_err: got %b expected %b", i, o_idle_err, e_err); else n_pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_hit();
    test_dirty_miss();
    test_indirect_write();
    test_clear_busy_req();
    test_bad_level();
`ifdef CACHE_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_fill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
